pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter register and instruction-fetch sequencer for the microcomputer's IF stage. Holds the current PC and presents it to the external PC+4 adder. Consumes the adder's sum to advance the PC. Issues one instruction-memory request at a time, and hands each fetched word to decode over a valid/ready handshake; branch/jump redirects from execute override sequential flow.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset
- EXC_VECTOR, 32'h0000_0180, PC loaded on a misaligned redirect (ALIGN_CHECK_EN only)

- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- pc  output  32  current PC register, drives the adder's a input
- pc_plus4  input  32  adder result, must equal pc+4 combinationally in the same cycle
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_target  input  32  new PC when redirect_valid=1
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch address, equals pc while imem_req=1
- imem_ack  input  1  memory accepts request and returns data this cycle
- imem_rdata  input  32  instruction word, valid when imem_ack=1
- if_valid  output  1  if_instr/if_pc hold a valid instruction
- if_instr  output  32  fetched instruction
- if_pc  output  32  address of if_instr
- if_ready  input  1  decode accepts instruction
- align_fault  output  1  one-cycle pulse on misaligned redirect

## Operation
- States: IDLE, FETCH, DROP, HOLD. Reset enters IDLE; IDLE -> FETCH unconditionally next cycle.
- imem_req = 1 in FETCH and DROP, else 0 (decoded from state). imem_addr = pc. Memory protocol: req/addr held stable until ack.
- FETCH, imem_ack=1, redirect_valid=0: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc_plus4, -> HOLD.
- FETCH, imem_ack=1, redirect_valid=1: data discarded, pc<=target, stay FETCH.
- FETCH, imem_ack=0, redirect_valid=1: target latched into pending register, -> DROP. pc is unchanged, so the address stays stable.
- FETCH, no ack, no redirect: stay.
- DROP: further redirects overwrite the pending target. When imem_ack=1, the data is discarded, pc<=pending target (or redirect_target if redirect_valid=1 that cycle), -> FETCH.
- HOLD: redirect_valid=1 takes priority. if_valid<=0, pc<=target, -> FETCH; the held instruction is dropped even if if_ready=1.
- HOLD: if_ready=1, no redirect: if_valid<=0, -> FETCH.
- HOLD: otherwise outputs are frozen.
- All arithmetic is 32-bit modulo; 0xFFFF_FFFC advances to 0x0000_0000 via the adder. No internal adder.

## Timing
- Reset values: pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, align_fault=0, imem_req=0, pending=0.
- rst is asynchronous: mid-fetch or mid-hold it abandons the transaction immediately. The outstanding request is dropped without waiting for ack.
- Zero-wait memory: rst deasserts before edge 0 -> IDLE at cycle 0, FETCH/req at cycle 1, if_valid=1 at cycle 2.
- Sustained rate with zero-wait memory and if_ready=1 is one instruction per 2 cycles (FETCH, HOLD).
- Redirect-to-request latency: 1 cycle (new address on imem_addr the cycle after the redirect, or after the DROP ack).
- if_valid never asserts for a wrong-path word.

## Configuration
- ALIGN_CHECK_EN defined: a redirect accepted with target[1:0]!=2'b00 loads EXC_VECTOR instead of the target. align_fault=1 for exactly the following cycle. In DROP the check applies to the target finally loaded.
- ALIGN_CHECK_EN undefined: target[1:0] is forced to 2'b00 on load; align_fault is tied 0.

## Test plan
- Reset, zero-wait memory returning 0x2000_0001, if_ready=1 -> if_pc sequence 0x0,0x4,0x8; if_valid at cycle 2, 4, 6.
- if_ready=0 for 5 cycles in HOLD -> if_instr/if_pc/pc frozen, imem_req=0; release -> next fetch at pc+4.
- In FETCH, ack delayed 3 cycles, redirect to 0x0000_0100 at wait cycle 1 -> imem_addr stays the old pc until ack. Data is discarded, then a request to 0x100 follows and if_pc=0x100.
- HOLD with if_ready=1 and redirect to 0x40 in the same cycle -> the held word is not consumed (if_valid drops), next if_pc=0x40.
- Redirect to 0x0000_0102: with ALIGN_CHECK_EN -> pc=0x180, align_fault pulses 1 cycle; without -> pc=0x100, align_fault=0.
- Assert rst while a FETCH is waiting for ack -> pc=RESET_PC, if_valid=0, imem_req=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// PC register and IF-stage fetch sequencer: one outstanding imem request, decode handoff over valid/ready.
// Optional build macro ALIGN_CHECK_EN: misaligned redirects vector to EXC_VECTOR and pulse align_fault.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        align_fault,
  output logic [1:0]  fsm_state
);

  // Handshakes: imem_req/imem_addr stay stable until imem_ack (data returns in the ack cycle);
  // a decode transfer happens on a clock edge with if_valid=1 and if_ready=1 and no redirect.
  typedef enum logic [1:0] {IDLE, FETCH, DROP, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic        load_en;
  logic [31:0] load_raw;
  logic [31:0] load_pc;
  logic        load_mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    instr_d  = instr_q;
    ifpc_d   = ifpc_q;
    valid_d  = valid_q;
    load_en  = 1'b0;
    load_raw = redirect_target;
    load_pc  = redirect_target;
    load_mis = 1'b0;
    fault_d  = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            load_en = 1'b1;
          end else begin
            instr_d = imem_rdata;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            state_d = HOLD;
          end
        end else if (redirect_valid) begin
          // Request still in flight: remember the target, keep the address stable.
          pend_d  = redirect_target;
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ack) begin
          load_en  = 1'b1;
          load_raw = redirect_valid ? redirect_target : pend_q;
          state_d  = FETCH;
        end else if (redirect_valid) begin
          pend_d = redirect_target;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          load_en = 1'b1;
          state_d = FETCH;
        end else if (if_ready) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
    endcase

`ifdef ALIGN_CHECK_EN
    load_mis = (load_raw[1:0] != 2'b00);
    load_pc  = load_mis ? EXC_VECTOR : load_raw;
`else
    load_mis = 1'b0;
    load_pc  = load_raw & 32'hFFFF_FFFC;
`endif

    if (load_en) pc_d = load_pc;
    fault_d = load_en & load_mis;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      pend_q  <= 32'h0;
      instr_q <= 32'h0;
      ifpc_q  <= 32'h0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == FETCH) || (state_q == DROP);
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ifpc_q;
  assign align_fault = fault_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then random traffic, checked against a transaction-level model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0180;
  localparam int P_IDLE = 0;
  localparam int P_FETCH = 1;
  localparam int P_HELD = 2;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic [31:0] pc, pc_plus4, redirect_target, imem_addr, imem_rdata, if_instr, if_pc;
  logic        redirect_valid, imem_req, imem_ack, if_valid, if_ready, align_fault;
  logic [1:0]  fsm_state;

  assign pc_plus4 = pc + 32'd4;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_plus4(pc_plus4),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .align_fault(align_fault), .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] seen_q[$];

  // reference model: what the fetch unit should be doing, per transaction
  int          m_phase;
  logic [31:0] m_pc, m_pend;
  logic        m_poison, m_fault;

  function automatic logic [31:0] fix_target(input logic [31:0] t);
`ifdef ALIGN_CHECK_EN
    return (t[1:0] != 2'b00) ? EXC_VECTOR : t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  function automatic logic is_mis(input logic [31:0] t);
`ifdef ALIGN_CHECK_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = P_IDLE;
    m_pc     = RESET_PC;
    m_pend   = 32'h0;
    m_poison = 1'b0;
    m_fault  = 1'b0;
    exp_q.delete();
  endtask

  // driver: one clock of stimulus, checking the cycle-level outputs first
  task automatic cycle(input logic rv, input logic [31:0] rt, input logic ack,
                       input logic [31:0] rd, input logic rdy);
    logic [31:0] tgt;
    @(negedge clk);
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("imem_req", 32'(imem_req), 32'(m_phase == P_FETCH));
    chk("if_valid", 32'(if_valid), 32'(m_phase == P_HELD));
    chk("align_fault", 32'(align_fault), 32'(m_fault));
    redirect_valid  = rv;
    redirect_target = rt;
    imem_ack        = ack;
    imem_rdata      = rd;
    if_ready        = rdy;
    m_fault = 1'b0;
    case (m_phase)
      P_IDLE: begin
        m_phase  = P_FETCH;
        m_poison = 1'b0;
      end
      P_FETCH: begin
        if (ack) begin
          if (m_poison || rv) begin
            tgt      = rv ? rt : m_pend;
            m_pc     = fix_target(tgt);
            m_fault  = is_mis(tgt);
            m_poison = 1'b0;
          end else begin
            exp_q.push_back({m_pc, rd});
            m_pc    = m_pc + 32'd4;
            m_phase = P_HELD;
          end
        end else if (rv) begin
          m_poison = 1'b1;
          m_pend   = rt;
        end
      end
      default: begin
        if (rv) begin
          m_pc    = fix_target(rt);
          m_fault = is_mis(rt);
          m_phase = P_FETCH;
        end else if (rdy) begin
          m_phase = P_FETCH;
        end
      end
    endcase
  endtask

  // monitor: each newly presented instruction is compared with the oldest expected word
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && if_valid && !prev_valid) begin
      seen_q.push_back(if_pc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL if_word: got pc=%h instr=%h expected no word", if_pc, if_instr);
      end else begin
        e = exp_q.pop_front();
        if ({if_pc, if_instr} !== e) begin
          errors++;
          $display("FAIL if_word: got pc=%h instr=%h expected pc=%h instr=%h",
                   if_pc, if_instr, e[63:32], e[31:0]);
        end
      end
    end
    prev_valid = if_valid;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [31:0] rt;
    logic [31:0] exp_pcs[6];
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; if_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_pc", pc, RESET_PC);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_align_fault", 32'(align_fault), 32'h0);
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // zero-wait memory, decode always ready
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 32'h2000_0001, 1'b1);
    // decode stall while holding the word at 0x8
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk("stall_if_pc", if_pc, 32'h8);
    chk("stall_if_instr", if_instr, 32'h2000_0001);
    chk("stall_pc", pc, 32'hC);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'h1111_0000, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    // slow ack with a redirect to 0x100 while waiting
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'h0000_1234, 1'b0);
    // redirect beats if_ready in HOLD
    cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'h0000_4040, 1'b0);
    // misaligned redirect from HOLD
    cycle(1'b1, 32'h102, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
`ifdef ALIGN_CHECK_EN
    chk("mis_pc", pc, 32'h180);
    chk("mis_fault", 32'(align_fault), 32'h1);
`else
    chk("mis_pc", pc, 32'h100);
    chk("mis_fault", 32'(align_fault), 32'h0);
`endif
    exp_pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h40};
    chk("seen_count", 32'(seen_q.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < seen_q.size()) chk("seen_if_pc", seen_q[i], exp_pcs[i]);

    // asynchronous reset while a fetch waits for ack
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #2;
    chk("pre_rst_req", 32'(imem_req), 32'h1);
    rst = 1'b1;
    #1;
    chk("async_pc", pc, RESET_PC);
    chk("async_if_valid", 32'(if_valid), 32'h0);
    chk("async_imem_req", 32'(imem_req), 32'h0);
    model_reset();
    #1 rst = 1'b0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0: rt = 32'hFFFF_FFFC;
        1, 2: rt = $urandom;
        default: rt = {22'h0, $urandom_range(0, 255), 2'b00};
      endcase
      cycle($urandom_range(0, 7) == 0, rt, $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 9) < 6);
    end

    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clk); #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
